// File: rtl/sram_bridge_pkg.sv
// Shared encodings and helpers for the 32-bit CPU to 16-bit async SRAM bridge.
package sram_bridge_pkg;

  localparam int unsigned LANE_W = 16;
  localparam int unsigned CNT_W  = 4;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_LO   = 2'd1;
  localparam logic [1:0] ST_HI   = 2'd2;
  localparam logic [1:0] ST_DONE = 2'd3;

  typedef struct packed {
    logic [LANE_W-1:0] hi;
    logic [LANE_W-1:0] lo;
  } rd_word_t;

  // Zero every byte whose lane enable is clear.
  function automatic logic [2*LANE_W-1:0] lane_mask(input rd_word_t w, input logic [3:0] sel);
    logic [2*LANE_W-1:0] m;
    for (int i = 0; i < 4; i++) begin
      m[i*8 +: 8] = sel[i] ? w[i*8 +: 8] : 8'h00;
    end
    return m;
  endfunction

endpackage

// File: rtl/sram_phase_timer.sv
// Down-counter timing one SRAM halfword phase of WAIT_CYCLES cycles.
module sram_phase_timer
  import sram_bridge_pkg::*;
#(
  parameter int unsigned WAIT_CYCLES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic load,
  output logic first_c,
  output logic last_c
);

  localparam logic [CNT_W-1:0] LOAD_VAL = CNT_W'(WAIT_CYCLES - 1);

  logic [CNT_W-1:0] cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= LOAD_VAL;
    end else if (cnt != '0) begin
      cnt <= cnt - CNT_W'(1);
    end
  end

  assign first_c = (cnt == LOAD_VAL);
  assign last_c  = (cnt == '0);

endmodule

// File: rtl/sram_bridge.sv
// CPU data-port to 16-bit async SRAM bridge: one 32-bit access as up to two halfword phases.
// Define SRAM_BRIDGE_ERR_EN to add err_o and reject addresses beyond the SRAM window.
module sram_bridge
  import sram_bridge_pkg::*;
#(
  parameter int unsigned WAIT_CYCLES = 2,
  parameter int unsigned SRAM_AW     = 20
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               ce_i,
  input  logic               we_i,
  input  logic [31:0]        addr_i,
  input  logic [3:0]         sel_i,
  input  logic [31:0]        data_i,
  output logic [31:0]        data_o,
  output logic               stallreq_o,
`ifdef SRAM_BRIDGE_ERR_EN
  output logic               err_o,
`endif
  output logic [SRAM_AW-1:0] sram_addr_o,
  input  logic [15:0]        sram_dq_i,
  output logic [15:0]        sram_dq_o,
  output logic               sram_dq_oe_o,
  output logic               sram_ce_n_o,
  output logic               sram_oe_n_o,
  output logic               sram_we_n_o,
  output logic [1:0]         sram_be_n_o
);

  logic [1:0] state, next_state;
  logic       req, in_phase, load, cap_lo, cap_hi, addr_err;
  logic       first_c, last_c;
  rd_word_t   rd_q, rd_n;
  logic       unused_addr_bits;

  assign req      = ce_i && (sel_i != 4'b0000);
  assign in_phase = (state == ST_LO) || (state == ST_HI);

`ifdef SRAM_BRIDGE_ERR_EN
  assign addr_err = (addr_i[31:SRAM_AW+1] != '0);
`else
  assign addr_err = 1'b0;
`endif
  assign unused_addr_bits = ^{addr_i[1:0], addr_i[31:SRAM_AW+1]};

  sram_phase_timer #(.WAIT_CYCLES(WAIT_CYCLES)) u_timer (
    .clk     (clk),
    .rst     (rst),
    .load    (load),
    .first_c (first_c),
    .last_c  (last_c)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= ST_IDLE;
    else     state <= next_state;
  end

  // Next state and SRAM pin decode; pins go inactive as soon as state leaves a phase.
  always_comb begin
    next_state   = state;
    sram_ce_n_o  = 1'b1;
    sram_oe_n_o  = 1'b1;
    sram_we_n_o  = 1'b1;
    sram_be_n_o  = 2'b11;
    sram_dq_oe_o = 1'b0;
    sram_dq_o    = '0;
    sram_addr_o  = '0;

    case (state)
      ST_IDLE: begin
        if (req) begin
          if (addr_err)                 next_state = ST_DONE;
          else if (sel_i[1:0] != 2'b00) next_state = ST_LO;
          else                          next_state = ST_HI;
        end
      end
      ST_LO: begin
        if (!ce_i)       next_state = ST_IDLE;
        else if (last_c) next_state = (sel_i[3:2] != 2'b00) ? ST_HI : ST_DONE;
      end
      ST_HI: begin
        if (!ce_i)       next_state = ST_IDLE;
        else if (last_c) next_state = ST_DONE;
      end
      default: next_state = ST_IDLE;
    endcase

    if (in_phase) begin
      sram_ce_n_o = 1'b0;
      sram_addr_o = {addr_i[SRAM_AW:2], (state == ST_HI)};
      sram_be_n_o = (state == ST_HI) ? ~sel_i[3:2] : ~sel_i[1:0];
      if (we_i) begin
        sram_dq_oe_o = 1'b1;
        sram_dq_o    = (state == ST_HI) ? data_i[31:16] : data_i[15:0];
        sram_we_n_o  = first_c;
      end else begin
        sram_oe_n_o  = 1'b0;
      end
    end
  end

  assign load = ((next_state == ST_LO) || (next_state == ST_HI)) && (next_state != state);

  assign stallreq_o = req && (state != ST_DONE);

  assign cap_lo  = (state == ST_LO) && ce_i && !we_i && last_c;
  assign cap_hi  = (state == ST_HI) && ce_i && !we_i && last_c;
  assign rd_n.lo = cap_lo ? sram_dq_i : rd_q.lo;
  assign rd_n.hi = cap_hi ? sram_dq_i : rd_q.hi;

  // Read data is assembled on the edge into DONE so it is valid throughout DONE.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_q   <= '0;
      data_o <= '0;
`ifdef SRAM_BRIDGE_ERR_EN
      err_o  <= 1'b0;
`endif
    end else begin
      rd_q <= rd_n;
      if (in_phase && (next_state == ST_DONE) && !we_i) begin
        data_o <= lane_mask(rd_n, sel_i);
      end
`ifdef SRAM_BRIDGE_ERR_EN
      else if ((state == ST_IDLE) && (next_state == ST_DONE)) begin
        data_o <= '0;
      end
      err_o <= (state == ST_IDLE) && (next_state == ST_DONE);
`endif
    end
  end

endmodule

// File: tb/tb_sram_bridge.sv
// Self-checking bench for sram_bridge (WAIT_CYCLES=2, SRAM_AW=20) with a small SRAM model.
module tb_sram_bridge;

  logic        clk = 1'b0;
  logic        rst;
  logic        ce_i, we_i;
  logic [31:0] addr_i, data_i, data_o;
  logic [3:0]  sel_i;
  logic        stallreq_o;
  logic [19:0] sram_addr_o;
  logic [15:0] sram_dq_i, sram_dq_o;
  logic        sram_dq_oe_o, sram_ce_n_o, sram_oe_n_o, sram_we_n_o;
  logic [1:0]  sram_be_n_o;
`ifdef SRAM_BRIDGE_ERR_EN
  logic        err_o;
`endif

  int checks = 0;
  int errors = 0;

  sram_bridge #(.WAIT_CYCLES(2), .SRAM_AW(20)) dut (
    .clk          (clk),
    .rst          (rst),
    .ce_i         (ce_i),
    .we_i         (we_i),
    .addr_i       (addr_i),
    .sel_i        (sel_i),
    .data_i       (data_i),
    .data_o       (data_o),
    .stallreq_o   (stallreq_o),
`ifdef SRAM_BRIDGE_ERR_EN
    .err_o        (err_o),
`endif
    .sram_addr_o  (sram_addr_o),
    .sram_dq_i    (sram_dq_i),
    .sram_dq_o    (sram_dq_o),
    .sram_dq_oe_o (sram_dq_oe_o),
    .sram_ce_n_o  (sram_ce_n_o),
    .sram_oe_n_o  (sram_oe_n_o),
    .sram_we_n_o  (sram_we_n_o),
    .sram_be_n_o  (sram_be_n_o)
  );

  always #5 clk = ~clk;

  // SRAM model: 256 halfwords, byte-lane writes sampled at the clock edge.
  logic [15:0] mem [0:255];
  logic        preload;

  assign sram_dq_i = (!sram_ce_n_o && !sram_oe_n_o) ? mem[sram_addr_o[7:0]] : 16'h0000;

  always @(posedge clk) begin
    if (preload) begin
      for (int i = 0; i < 256; i++) mem[i] <= 16'h0000;
      mem[8'h80] <= 16'hBEEF;
      mem[8'h81] <= 16'hDEAD;
    end else if (!sram_ce_n_o && !sram_we_n_o) begin
      if (!sram_be_n_o[0]) mem[sram_addr_o[7:0]][7:0]  <= sram_dq_o[7:0];
      if (!sram_be_n_o[1]) mem[sram_addr_o[7:0]][15:8] <= sram_dq_o[15:8];
    end
  end

  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [3:0]  sel;
    logic [31:0] wdata;
    logic [31:0] exp_data;
    int          exp_stall;
    int          exp_ce;
    int          exp_we;
    logic        exp_err;
  } vec_t;

  vec_t vecs [10];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic run_vec(input vec_t v, input int idx);
    int st, cel, wel;
    bit done;
    st = 0; cel = 0; wel = 0; done = 1'b0;
    @(posedge clk); #1;
    ce_i = 1'b1; we_i = v.we; addr_i = v.addr; sel_i = v.sel; data_i = v.wdata;
    for (int c = 0; c < 40 && !done; c++) begin
      @(negedge clk);
      if (stallreq_o) st++;
      else            done = 1'b1;
      if (!sram_ce_n_o) cel++;
      if (!sram_we_n_o) wel++;
    end
    chk($sformatf("v%0d finished", idx), 32'(done), 32'd1);
    chk($sformatf("v%0d stall cycles", idx), 32'(st), 32'(v.exp_stall));
    chk($sformatf("v%0d ce_n low cycles", idx), 32'(cel), 32'(v.exp_ce));
    chk($sformatf("v%0d we_n low cycles", idx), 32'(wel), 32'(v.exp_we));
    chk($sformatf("v%0d data_o", idx), data_o, v.exp_data);
`ifdef SRAM_BRIDGE_ERR_EN
    chk($sformatf("v%0d err_o", idx), 32'(err_o), 32'(v.exp_err));
`endif
    @(posedge clk); #1;
    ce_i = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  initial begin
    int cel;
    bit seen;
    logic [31:0] exp_last;

    //              we    addr           sel     wdata          exp_data       st ce we err
    vecs[0] = '{1'b0, 32'h0000_0100, 4'b1111, 32'h0,         32'hDEAD_BEEF, 5, 4, 0, 1'b0};
    vecs[1] = '{1'b1, 32'h0000_0100, 4'b0011, 32'h1234_5678, 32'hDEAD_BEEF, 3, 2, 1, 1'b0};
    vecs[2] = '{1'b0, 32'h0000_0100, 4'b1000, 32'h0,         32'hDE00_0000, 3, 2, 0, 1'b0};
    vecs[3] = '{1'b0, 32'h0000_0100, 4'b1111, 32'h0,         32'hDEAD_5678, 5, 4, 0, 1'b0};
    vecs[4] = '{1'b0, 32'h0000_0100, 4'b0000, 32'h0,         32'hDEAD_5678, 0, 0, 0, 1'b0};
    vecs[5] = '{1'b1, 32'h0000_0104, 4'b1111, 32'hCAFE_F00D, 32'hDEAD_5678, 5, 4, 2, 1'b0};
    vecs[6] = '{1'b0, 32'h0000_0104, 4'b0110, 32'h0,         32'h00FE_F000, 5, 4, 0, 1'b0};
    vecs[7] = '{1'b1, 32'h0000_0108, 4'b0100, 32'h00AB_0000, 32'h00FE_F000, 3, 2, 1, 1'b0};
    vecs[8] = '{1'b0, 32'h0000_0108, 4'b1100, 32'h0,         32'h00AB_0000, 3, 2, 0, 1'b0};
`ifdef SRAM_BRIDGE_ERR_EN
    vecs[9] = '{1'b0, 32'h0040_0100, 4'b1111, 32'h0,         32'h0000_0000, 1, 0, 0, 1'b1};
`else
    vecs[9] = '{1'b0, 32'h0040_0100, 4'b1111, 32'h0,         32'hDEAD_5678, 5, 4, 0, 1'b0};
`endif
    exp_last = vecs[9].exp_data;

    rst = 1'b1; preload = 1'b1;
    ce_i = 1'b0; we_i = 1'b0; addr_i = '0; sel_i = '0; data_i = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("reset data_o", data_o, 32'h0);
    chk("reset ctrl_n", 32'({sram_ce_n_o, sram_oe_n_o, sram_we_n_o, sram_be_n_o}), 32'h1F);
    chk("reset dq_oe/dq_o", 32'({sram_dq_oe_o, sram_dq_o}), 32'h0);
    chk("reset addr", 32'(sram_addr_o), 32'h0);
    chk("reset stall", 32'(stallreq_o), 32'h0);
    rst = 1'b0; preload = 1'b0;

    for (int i = 0; i < 10; i++) run_vec(vecs[i], i);

    // Abort: ce_i dropped in the second LO cycle.
    @(posedge clk); #1;
    ce_i = 1'b1; we_i = 1'b0; addr_i = 32'h0000_0100; sel_i = 4'b1111;
    @(posedge clk);
    @(posedge clk); #1;
    ce_i = 1'b0;
    @(negedge clk);
    chk("abort stall after drop", 32'(stallreq_o), 32'h0);
    @(posedge clk); #1;
    chk("abort ce_n idle", 32'(sram_ce_n_o), 32'h1);
    chk("abort data_o held", data_o, exp_last);
    cel = 0;
    repeat (4) begin
      @(negedge clk);
      if (!sram_ce_n_o) cel++;
    end
    chk("abort no later strobes", 32'(cel), 32'h0);

    // Back-to-back: request held through DONE restarts from IDLE.
    @(posedge clk); #1;
    ce_i = 1'b1; we_i = 1'b0; addr_i = 32'h0000_0100; sel_i = 4'b1111;
    seen = 1'b0;
    for (int c = 0; c < 20 && !seen; c++) begin
      @(negedge clk);
      if (!stallreq_o) seen = 1'b1;
    end
    chk("b2b reached done", 32'(seen), 32'h1);
    chk("b2b data_o", data_o, 32'hDEAD_5678);
    @(negedge clk);
    chk("b2b idle stall/ce_n", 32'({stallreq_o, sram_ce_n_o}), 32'h3);
    @(negedge clk);
    chk("b2b lo ce_n/addr", 32'({sram_ce_n_o, sram_addr_o}), 32'h0_0080);
    @(posedge clk); #1;
    ce_i = 1'b0;
    repeat (2) @(posedge clk);

    // Reset pulsed during the second HI write cycle.
    #1;
    ce_i = 1'b1; we_i = 1'b1; addr_i = 32'h0000_010C; sel_i = 4'b1111; data_i = 32'h1111_2222;
    repeat (4) @(posedge clk);
    @(negedge clk);
    chk("rst pre we_n/addr", 32'({sram_we_n_o, sram_addr_o}), 32'h0_0087);
    #2;
    rst = 1'b1; ce_i = 1'b0;
    #1;
    chk("rst ctrl_n", 32'({sram_ce_n_o, sram_oe_n_o, sram_we_n_o, sram_be_n_o}), 32'h1F);
    chk("rst dq_oe/dq_o", 32'({sram_dq_oe_o, sram_dq_o}), 32'h0);
    chk("rst addr", 32'(sram_addr_o), 32'h0);
    chk("rst data_o", data_o, 32'h0);
    #1;
    rst = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst lo half written", 32'(mem[8'h86]), 32'h2222);
    chk("rst hi half untouched", 32'(mem[8'h87]), 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
